// File: rtl/moore_pkg.sv
// Shared constants, width helper and operation decode for the Moore serial
// pattern detector family.
package moore_pkg;

  localparam int DEF_N = 4;
  localparam logic [3:0] DEF_RESET_PATTERN = 4'b1101;
  localparam int DEF_CW = 4;

  // State counts matched prefix length 0..N, so it needs clog2(N+1) bits.
  function automatic int state_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Per-cycle operation; load outranks a valid bit in the same cycle.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2
  } op_e;

endpackage

// File: rtl/moore_seq_if.sv
// Signal bundle between a driver of serial bits and the pattern detector.
// Inputs are sampled every rising edge; x_in only counts when x_valid is high
// and pat_load is low, and there is no back-pressure.
interface moore_seq_if #(
  parameter int N  = 4,
  parameter int CW = 4,
  parameter int SW = 3
);
  logic          x_in;
  logic          x_valid;
  logic          overlap;
  logic          pat_load;
  logic [N-1:0]  pat_in;
  logic [SW-1:0] state;
  logic          match;
  logic [CW-1:0] match_count;
  logic [N-1:0]  pattern;

  modport master (
    output x_in, x_valid, overlap, pat_load, pat_in,
    input  state, match, match_count, pattern
  );

  modport slave (
    input  x_in, x_valid, overlap, pat_load, pat_in,
    output state, match, match_count, pattern
  );
endinterface

// File: rtl/moore_seq_detector_prefix_match.sv
// Combinational longest-prefix search: largest k <= len such that the newest
// k history bits equal the first k pattern bits in arrival order.
module seq_prefix_match #(
  parameter int N  = 4,
  parameter int SW = 3
) (
  input  logic [N-1:0]  hist_new,
  input  logic [SW-1:0] len,
  input  logic [N-1:0]  pat,
  output logic [SW-1:0] next_state
);

  logic hit;

  always_comb begin
    next_state = '0;
    hit        = 1'b0;
    for (int k = 1; k <= N; k++) begin
      hit = 1'b1;
      // hist_new[0] is newest, so pattern bit i lines up with hist_new[k-1-i].
      for (int i = 0; i < k; i++) begin
        if (pat[i] != hist_new[k-1-i]) hit = 1'b0;
      end
      if (hit && (k <= int'(len))) next_state = SW'(k);
    end
  end

endmodule

// File: rtl/tt_um_moore_seq_detector.sv
// Tiny Tapeout style pin wrapper around the default-sized detector.
module tt_um_moore_seq_detector (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  moore_seq_if #(.N(4), .CW(4), .SW(3)) det_bus ();

  assign det_bus.x_in     = ui_in[0];
  assign det_bus.x_valid  = ui_in[1];
  assign det_bus.overlap  = ui_in[2];
  assign det_bus.pat_load = ui_in[3];
  assign det_bus.pat_in   = uio_in[3:0];

  moore_seq_detector u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (det_bus)
  );

  assign uo_out  = {det_bus.match_count, det_bus.match, det_bus.state};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_pins;
  assign unused_pins = &{1'b0, ena, ui_in[7:4], uio_in[7:4], det_bus.pattern};

endmodule

// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial pattern detector with runtime-loadable pattern,
// overlap/non-overlap modes and a saturating match counter.
module moore_seq_detector
  import moore_pkg::*;
#(
  parameter int             N             = DEF_N,
  parameter logic [N-1:0]   RESET_PATTERN = N'(DEF_RESET_PATTERN),
  parameter int             CW            = DEF_CW,
  parameter int             SW            = state_width(N)
) (
  input logic        clk,
  input logic        rst_n,
  moore_seq_if.slave bus
);

  localparam logic [SW-1:0] MATCH_STATE = SW'(N);

  logic [SW-1:0] state_q, state_d;
  logic [N-1:0]  hist_q, hist_d;
  logic [SW-1:0] hist_len_q, hist_len_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  pat_q, pat_d;
  logic          match_q, match_d;

  op_e           op;
  logic [N-1:0]  hist_new;
  logic [SW-1:0] len_sel;
  logic [SW-1:0] pm_next;

  always_comb begin
    op = OP_HOLD;
    if (bus.pat_load)     op = OP_LOAD;
    else if (bus.x_valid) op = OP_SHIFT;
  end

  assign hist_new = {hist_q[N-2:0], bus.x_in};

  // In non-overlap mode a completed match fences off everything before the
  // next bit, so only that new bit may start a prefix.
  always_comb begin
    len_sel = (hist_len_q == MATCH_STATE) ? MATCH_STATE : hist_len_q + 1'b1;
    if ((state_q == MATCH_STATE) && !bus.overlap) len_sel = SW'(1);
  end

  seq_prefix_match #(
    .N  (N),
    .SW (SW)
  ) u_prefix_match (
    .hist_new   (hist_new),
    .len        (len_sel),
    .pat        (pat_q),
    .next_state (pm_next)
  );

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    hist_len_d = hist_len_q;
    count_d    = count_q;
    pat_d      = pat_q;
    case (op)
      OP_SHIFT: begin
        state_d    = pm_next;
        hist_d     = hist_new;
        hist_len_d = len_sel;
        if ((pm_next == MATCH_STATE) && (count_q != '1)) count_d = count_q + 1'b1;
      end
      OP_LOAD: begin
        pat_d      = bus.pat_in;
        state_d    = '0;
        hist_len_d = '0;
        count_d    = '0;
      end
      default: ;
    endcase
    match_d = (state_d == MATCH_STATE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= '0;
      hist_q     <= '0;
      hist_len_q <= '0;
      count_q    <= '0;
      pat_q      <= RESET_PATTERN;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      hist_len_q <= hist_len_d;
      count_q    <= count_d;
      pat_q      <= pat_d;
      match_q    <= match_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.match       = match_q;
  assign bus.match_count = count_q;
  assign bus.pattern     = pat_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: each driven cycle pushes its
// expected {pattern, count, match, state}; a negedge monitor pops and checks.
module tb_moore_seq_detector;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int SW = 3;
  localparam int EW = N + CW + 1 + SW;

  logic clk;
  logic rst_n;

  moore_seq_if #(.N(N), .CW(CW), .SW(SW)) bus ();

  moore_seq_detector u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            tag_q[$];
  int            total = 0;
  int            bad   = 0;
  logic [N-1:0]  exp_pat;
  int            step_no = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] exp_v;
      logic [EW-1:0] act_v;
      int            tag;
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      act_v = {bus.pattern, bus.match_count, bus.match, bus.state};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL step%0d: got pat=%b cnt=%0d match=%b state=%0d, want pat=%b cnt=%0d match=%b state=%0d",
                 tag, act_v[EW-1 -: N], act_v[SW+1 +: CW], act_v[SW], act_v[SW-1:0],
                 exp_v[EW-1 -: N], exp_v[SW+1 +: CW], exp_v[SW], exp_v[SW-1:0]);
      end
    end
  end

  // driver: apply one cycle of inputs, then record what must be visible after the edge
  task automatic step(input logic rst, input logic x, input logic v, input logic ovl,
                      input logic ld, input logic [N-1:0] pin, input int es, input int ec);
    rst_n        = ~rst;
    bus.x_in     = x;
    bus.x_valid  = v;
    bus.overlap  = ovl;
    bus.pat_load = ld;
    bus.pat_in   = pin;
    if (rst)     exp_pat = 4'b1101;
    else if (ld) exp_pat = pin;
    @(posedge clk);
    #1;
    step_no++;
    exp_q.push_back({exp_pat, CW'(ec), (es == N), SW'(es)});
    tag_q.push_back(step_no);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 0, 0);
  endtask

  int bits1[7] = '{1, 0, 1, 1, 0, 1, 1};
  int st_ov[7] = '{1, 2, 3, 4, 2, 3, 4};
  int ct_ov[7] = '{0, 0, 0, 1, 1, 1, 2};
  int st_no[7] = '{1, 2, 3, 4, 0, 1, 1};
  int ct_no[7] = '{0, 0, 0, 1, 1, 1, 1};
  int st_11[6] = '{1, 2, 3, 4, 4, 4};
  int ct_11[6] = '{0, 0, 0, 1, 2, 3};

  initial begin
    exp_pat      = 4'b1101;
    rst_n        = 1'b0;
    bus.x_in     = 1'b0;
    bus.x_valid  = 1'b0;
    bus.overlap  = 1'b1;
    bus.pat_load = 1'b0;
    bus.pat_in   = '0;

    do_reset();
    do_reset();

    // overlapping detection of 1101
    for (int i = 0; i < 7; i++)
      step(1'b0, bits1[i][0], 1'b1, 1'b1, 1'b0, 4'b0000, st_ov[i], ct_ov[i]);

    // non-overlapping
    do_reset();
    for (int i = 0; i < 7; i++)
      step(1'b0, bits1[i][0], 1'b1, 1'b0, 1'b0, 4'b0000, st_no[i], ct_no[i]);

    // invalid cycles in between carry the opposite bit, which must be ignored
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, bits1[i][0], 1'b1, 1'b1, 1'b0, 4'b0000, st_ov[i], ct_ov[i]);
      step(1'b0, ~bits1[i][0], 1'b0, 1'b1, 1'b0, 4'b0000, st_ov[i], ct_ov[i]);
    end

    // load all-ones pattern, consecutive overlapping matches
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 0, 0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, st_11[i], ct_11[i]);
    // load with a valid bit present: bit is discarded
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 0, 0);

    // counter saturation: 20 ones
    for (int k = 1; k <= 20; k++)
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, (k < 4) ? k : 4, (k < 4) ? 0 : ((k - 3 > 15) ? 15 : k - 3));

    // mid-stream reset restores the default pattern and drops the partial match
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 3, 0);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1, 0);

    // overlap changed right after a match affects only the next bit
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 3, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2, 1);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
